// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants and sizing helpers for the FIFO pointer controller.
//   ADDR_W_DEF : default RAM address width
//   PTR_W_DEF  : default pointer width (address + wrap bit)
//   ptr_t      : pointer type at the default width
//   ptr_width  : pointer width for a given address width
//   fifo_depth : number of RAM entries for a given address width
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned PTR_W_DEF  = ADDR_W_DEF + 1;

    typedef logic [PTR_W_DEF-1:0] ptr_t;

    function automatic int unsigned ptr_width(input int unsigned aw);
        return aw + 1;
    endfunction

    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// ---------------------------------------------------------------------------
// fifo_ptr_cnt
// Plain binary pointer register (address bits plus wrap bit).
//   i_clk      : clock
//   i_rst      : synchronous active-high reset to 0
//   i_clr      : synchronous clear to 0
//   i_load     : load i_load_val
//   i_load_val : value loaded when i_load is high
//   i_inc      : increment by one, wrapping modulo 2**W
//   o_ptr      : current pointer value
// Priority: reset > clear > load > increment.
// ---------------------------------------------------------------------------
module fifo_ptr_cnt
    import fifo_pkg::*;
#(
    parameter int unsigned W = PTR_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);

    logic [W-1:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_ptr <= '0;
        end else if (i_load) begin
            r_ptr <= i_load_val;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ptr_ctrl
// Read/write pointer controller for an external dual-port RAM. Holds no data.
//   clk, rst        : clock, synchronous active-high reset
//   wr, rd          : write / read requests
//   flush           : synchronous clear of pointers and sticky flags
//   mark, rewind    : save / restore read pointer (only when RETRANSMIT=1)
//   write_address   : RAM write address
//   read_address    : RAM read address
//   fifo_we, fifo_rd: qualified write / read strobes
//   full, empty, almost_full, almost_empty : status
//   count           : occupancy 0..DEPTH
//   overflow, underflow : sticky error flags
// All status is decoded from registered pointers, so no input reaches a flag
// combinationally; only the strobes depend on the current requests.
// ---------------------------------------------------------------------------
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int          AF_LEVEL   = int'(fifo_depth(ADDR_W)) - 4,
    parameter int          AE_LEVEL   = 4,
    parameter int          RETRANSMIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic              flush,
    input  logic              mark,
    input  logic              rewind,
    output logic [ADDR_W-1:0] write_address,
    output logic [ADDR_W-1:0] read_address,
    output logic              fifo_we,
    output logic              fifo_rd,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned   PW      = ptr_width(ADDR_W);
    localparam logic [PW-1:0] DEPTH_V = PW'(fifo_depth(ADDR_W));
    localparam logic [PW-1:0] AF_V    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_V    = PW'(AE_LEVEL);
    localparam logic          RT      = (RETRANSMIT != 0);

    logic [PW-1:0] w_wr_ptr;
    logic [PW-1:0] w_rd_ptr;
    logic [PW-1:0] w_mark_ptr;
    logic [PW-1:0] w_base_ptr;
    logic [PW-1:0] w_count;
    logic [PW-1:0] w_used;
    logic          w_mark_en;
    logic          w_rewind_en;
    logic          w_full;
    logic          w_empty;
    logic          w_we;
    logic          w_rd;
    logic          r_overflow;
    logic          r_underflow;

    assign w_mark_en   = RT & mark;
    assign w_rewind_en = RT & rewind;

    // In retransmit mode space is only freed once the mark moves past it.
    assign w_base_ptr = RT ? w_mark_ptr : w_rd_ptr;
    assign w_count    = w_wr_ptr - w_rd_ptr;
    assign w_used     = w_wr_ptr - w_base_ptr;

    assign w_empty = (w_count == '0);
    assign w_full  = (w_used == DEPTH_V);

    assign w_rd = rd & ~w_empty & ~w_rewind_en & ~flush;
    // A read at full frees a slot in the same cycle only when reads are final.
    assign w_we = wr & ~flush & (~w_full | (w_rd & ~RT));

    fifo_ptr_cnt #(.W(PW)) u_wr_ptr (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clr      (flush),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (w_we),
        .o_ptr      (w_wr_ptr)
    );

    fifo_ptr_cnt #(.W(PW)) u_rd_ptr (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clr      (flush),
        .i_load     (w_rewind_en),
        .i_load_val (w_mark_ptr),
        .i_inc      (w_rd),
        .o_ptr      (w_rd_ptr)
    );

    // Mark captures the pre-increment read pointer; rewind suppresses it.
    fifo_ptr_cnt #(.W(PW)) u_mark_ptr (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clr      (flush),
        .i_load     (w_mark_en & ~w_rewind_en),
        .i_load_val (w_rd_ptr),
        .i_inc      (1'b0),
        .o_ptr      (w_mark_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr && w_full && !w_we) begin
                r_overflow <= 1'b1;
            end
            if (rd && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign write_address = w_wr_ptr[ADDR_W-1:0];
    assign read_address  = w_rd_ptr[ADDR_W-1:0];
    assign fifo_we       = w_we;
    assign fifo_rd       = w_rd;
    assign full          = w_full;
    assign empty         = w_empty;
    assign almost_full   = (w_count >= AF_V);
    assign almost_empty  = (w_count <= AE_V);
    assign count         = w_count;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl: two instances (plain and retransmit) share the same
// stimulus; a pointer model using unbounded integers is compared on every
// falling edge, and scenario-specific literal expectations pin the model.
module tb_fifo_ptr_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic s_rst, s_wr, s_rd, s_flush, s_mark, s_rewind;

    logic [2:0] wa  [2];
    logic [2:0] ra  [2];
    logic [3:0] cnt [2];
    logic       we  [2];
    logic       rdo [2];
    logic       fu  [2];
    logic       em  [2];
    logic       af  [2];
    logic       ae  [2];
    logic       ov  [2];
    logic       un  [2];

    fifo_ptr_ctrl #(.ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(1), .RETRANSMIT(0)) dut0 (
        .clk(clk), .rst(s_rst), .wr(s_wr), .rd(s_rd), .flush(s_flush),
        .mark(s_mark), .rewind(s_rewind),
        .write_address(wa[0]), .read_address(ra[0]),
        .fifo_we(we[0]), .fifo_rd(rdo[0]),
        .full(fu[0]), .empty(em[0]), .almost_full(af[0]), .almost_empty(ae[0]),
        .count(cnt[0]), .overflow(ov[0]), .underflow(un[0])
    );

    fifo_ptr_ctrl #(.ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(1), .RETRANSMIT(1)) dut1 (
        .clk(clk), .rst(s_rst), .wr(s_wr), .rd(s_rd), .flush(s_flush),
        .mark(s_mark), .rewind(s_rewind),
        .write_address(wa[1]), .read_address(ra[1]),
        .fifo_we(we[1]), .fifo_rd(rdo[1]),
        .full(fu[1]), .empty(em[1]), .almost_full(af[1]), .almost_empty(ae[1]),
        .count(cnt[1]), .overflow(ov[1]), .underflow(un[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: pointers are plain counts of words written/read, never wrapped.
    int wp [2];
    int rp [2];
    int mp [2];
    bit mov [2];
    bit mun [2];
    bit mvalid = 1'b0;

    function automatic int m_cnt(input int k);
        return wp[k] - rp[k];
    endfunction

    function automatic bit m_full(input int k);
        return (wp[k] - ((k == 1) ? mp[k] : rp[k])) == 8;
    endfunction

    function automatic bit m_rd(input int k);
        return s_rd && (m_cnt(k) != 0) && !(k == 1 && s_rewind) && !s_flush;
    endfunction

    function automatic bit m_we(input int k);
        return s_wr && !s_flush && (!m_full(k) || (m_rd(k) && k != 1));
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit e_rd;
            bit e_we;
            int old_rp;
            if (s_rst || s_flush) begin
                wp[k] = 0; rp[k] = 0; mp[k] = 0; mov[k] = 0; mun[k] = 0;
            end else begin
                e_rd = m_rd(k);
                e_we = m_we(k);
                old_rp = rp[k];
                if (s_wr && m_full(k) && !e_we) mov[k] = 1'b1;
                if (s_rd && m_cnt(k) == 0) mun[k] = 1'b1;
                if (k == 1 && s_rewind) rp[k] = mp[k];
                else if (e_rd) rp[k] = rp[k] + 1;
                if (e_we) wp[k] = wp[k] + 1;
                if (k == 1 && s_mark && !s_rewind) mp[k] = old_rp;
            end
        end
        if (s_rst) mvalid = 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("d%0d_waddr", k), int'(wa[k]), wp[k] % 8);
                chk($sformatf("d%0d_raddr", k), int'(ra[k]), rp[k] % 8);
                chk($sformatf("d%0d_count", k), int'(cnt[k]), m_cnt(k));
                chk($sformatf("d%0d_empty", k), int'(em[k]), int'(m_cnt(k) == 0));
                chk($sformatf("d%0d_full", k), int'(fu[k]), int'(m_full(k)));
                chk($sformatf("d%0d_afull", k), int'(af[k]), int'(m_cnt(k) >= 6));
                chk($sformatf("d%0d_aempty", k), int'(ae[k]), int'(m_cnt(k) <= 1));
                chk($sformatf("d%0d_ovf", k), int'(ov[k]), int'(mov[k]));
                chk($sformatf("d%0d_unf", k), int'(un[k]), int'(mun[k]));
                if (!s_rst) begin
                    chk($sformatf("d%0d_we", k), int'(we[k]), int'(m_we(k)));
                    chk($sformatf("d%0d_rd", k), int'(rdo[k]), int'(m_rd(k)));
                end
            end
        end
    end

    task automatic drive(input bit w, input bit r, input bit f,
                         input bit m, input bit rw, input bit rs);
        s_wr = w; s_rd = r; s_flush = f; s_mark = m; s_rewind = rw; s_rst = rs;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit w, input bit r, input bit f,
                       input bit m, input bit rw, input bit rs);
        drive(w, r, f, m, rw, rs);
        tick();
    endtask

    task automatic writes(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic reads(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 1);
        tick();
        tick();
        chk("rst_count", int'(cnt[0]), 0);
        chk("rst_empty", int'(em[0]), 1);
        chk("rst_aempty", int'(ae[0]), 1);
        chk("rst_full", int'(fu[0]), 0);

        // Reset mid-stream, with a write in the reset cycle.
        writes(5);
        chk("pre_rst_count", int'(cnt[0]), 5);
        cyc(1, 0, 0, 0, 0, 1);
        chk("midrst_count", int'(cnt[0]), 0);
        chk("midrst_empty", int'(em[0]), 1);
        chk("midrst_waddr", int'(wa[0]), 0);
        chk("midrst_raddr", int'(ra[0]), 0);

        // Fill, overflow, drain through the wrap.
        writes(8);
        chk("fill_full", int'(fu[0]), 1);
        chk("fill_count", int'(cnt[0]), 8);
        chk("fill_waddr", int'(wa[0]), 0);
        drive(1, 0, 0, 0, 0, 0);
        chk("ovf_we", int'(we[0]), 0);
        tick();
        chk("ovf_flag", int'(ov[0]), 1);
        reads(8);
        chk("drain_empty", int'(em[0]), 1);
        chk("drain_raddr", int'(ra[0]), 0);
        chk("drain_wwrap", int'(dut0.w_wr_ptr[3]), 1);
        chk("drain_rwrap", int'(dut0.w_rd_ptr[3]), 1);
        chk("rt_full_after_drain", int'(fu[1]), 1);

        // Simultaneous read/write at full and at empty.
        writes(8);
        drive(1, 1, 0, 0, 0, 0);
        chk("full_rw_we", int'(we[0]), 1);
        chk("full_rw_rd", int'(rdo[0]), 1);
        tick();
        chk("full_rw_count", int'(cnt[0]), 8);
        cyc(0, 0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        chk("empty_rw_we", int'(we[0]), 1);
        chk("empty_rw_rd", int'(rdo[0]), 0);
        tick();
        chk("empty_rw_count", int'(cnt[0]), 1);
        chk("empty_rw_unf", int'(un[0]), 1);

        // Almost flags.
        cyc(0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            writes(1);
            chk($sformatf("ae_at_%0d", k), int'(ae[0]), int'(k <= 1));
            chk($sformatf("af_at_%0d", k), int'(af[0]), int'(k >= 6));
        end

        // Flush with overflow set and four words held.
        writes(2);
        writes(1);
        reads(4);
        chk("pre_flush_ovf", int'(ov[0]), 1);
        chk("pre_flush_count", int'(cnt[0]), 4);
        drive(1, 0, 1, 0, 0, 0);
        chk("flush_we", int'(we[0]), 0);
        tick();
        chk("flush_count", int'(cnt[0]), 0);
        chk("flush_ovf", int'(ov[0]), 0);
        chk("flush_waddr", int'(wa[0]), 0);

        // Retransmit.
        cyc(0, 0, 0, 0, 0, 0);
        writes(5);
        cyc(0, 0, 0, 1, 0, 0);
        reads(3);
        chk("rt_count_after_reads", int'(cnt[1]), 2);
        cyc(0, 0, 0, 0, 1, 0);
        chk("rt_count_after_rewind", int'(cnt[1]), 5);
        chk("rt_raddr_after_rewind", int'(ra[1]), 0);
        drive(0, 1, 0, 0, 1, 0);
        chk("rt_rd_with_rewind", int'(rdo[1]), 0);
        tick();
        writes(3);
        chk("rt_full", int'(fu[1]), 1);
        chk("rt_count8", int'(cnt[1]), 8);
        reads(2);
        chk("rt_count6", int'(cnt[1]), 6);
        chk("rt_full_held", int'(fu[1]), 1);
        cyc(0, 1, 0, 1, 0, 0);
        chk("rt_markrd_count", int'(cnt[1]), 5);
        chk("rt_markrd_full", int'(fu[1]), 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("rt_rewind2_count", int'(cnt[1]), 6);
        chk("rt_rewind2_raddr", int'(ra[1]), 2);
        cyc(0, 1, 0, 1, 1, 0);
        reads(2);
        cyc(0, 0, 0, 0, 1, 0);
        chk("rt_mark_rewind_same", int'(ra[1]), 2);

        cyc(0, 0, 0, 0, 0, 0);
        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
- Parametrised read/write pointer controller for the FPGA-side FIFOs; successor to the single read-address counter.
- Owns both pointers, occupancy, full/empty/almost flags, sticky error flags, flush, and an optional mark/rewind (retransmit) mode.
- Drives the address and enable pins of an external dual-port RAM (fifo_mem); holds no data itself.

Parameters:
- ADDR_W, 12, RAM address width; DEPTH = 2**ADDR_W entries.
- AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL.
- RETRANSMIT, 0, 1 enables mark/rewind; 0 ties mark/rewind off internally.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr  in  1  write request.
- rd  in  1  read request.
- flush  in  1  synchronous clear of pointers/flags.
- mark  in  1  save current read pointer (RETRANSMIT=1).
- rewind  in  1  restore read pointer to mark (RETRANSMIT=1).
- write_address  out  ADDR_W  RAM write address.
- read_address  out  ADDR_W  RAM read address.
- fifo_we  out  1  qualified write strobe.
- fifo_rd  out  1  qualified read strobe.
- full, empty, almost_full, almost_empty  out  1 each  status.
- count  out  ADDR_W+1  live occupancy, 0..DEPTH.
- overflow, underflow  out  1 each  sticky error flags.

Behaviour:
- Internal wr_ptr, rd_ptr, mark_ptr: ADDR_W+1 bits (MSB = wrap bit). Addresses = low ADDR_W bits. Increments wrap modulo 2**(ADDR_W+1).
- Reset (rst=1 at posedge): all pointers 0; count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0. Outputs hold these values from the first edge with rst high.
- Priority, highest first: rst > flush > rewind > read/write > mark.
- base_ptr = mark_ptr if RETRANSMIT else rd_ptr.
- count = wr_ptr - rd_ptr. used = wr_ptr - base_ptr.
- Flags are combinational from registered pointers (no input-to-flag path):
  - empty = (count == 0).
  - full = (used == DEPTH).
  - Almost flags compare count.
- fifo_rd = rd & ~empty & ~rewind & ~flush.
- fifo_we = wr & ~flush & (~full | (fifo_rd & ~RETRANSMIT)). Full plus simultaneous read allows the write in non-retransmit mode. Empty plus simultaneous write blocks the read (no fall-through).
- Pointer update: wr_ptr +1 on fifo_we; rd_ptr +1 on fifo_rd. Visible on the address outputs and in count one cycle after the strobe edge. Simultaneous accepted rd and wr leave count unchanged.
- mark: mark_ptr <= rd_ptr (pre-increment value of that cycle). Mark asserted together with a read therefore includes the word read that cycle.
- rewind: rd_ptr <= mark_ptr. count rises accordingly. No read occurs that cycle.
- Rewind and mark in the same cycle: rewind only; mark_ptr unchanged.
- flush: wr_ptr, rd_ptr, mark_ptr <= 0; sticky flags cleared; wr/rd ignored that cycle.
- overflow sets when wr & full & ~fifo_we. underflow sets when rd & empty. Both hold until rst or flush.
- When RETRANSMIT=0, mark and rewind are ignored and mark_ptr stays 0.

Decomposition:
- Shared package fifo_pkg: ADDR_W default, the ptr_t width helper (ADDR_W+1), and a function computing the DEPTH constant.
- One sub-module, fifo_ptr_cnt: a gray-free binary ADDR_W+1-bit pointer register with inc, load, load_val, and clr inputs. Instantiate it three times (wr, rd, mark).

Test Plan (ADDR_W=3, DEPTH=8, AF=6, AE=1):
- Reset mid-stream: after 5 writes assert rst one cycle -> next cycle count=0, empty=1, addresses 0; a wr in the rst cycle is dropped.
- Fill/wrap: 8 writes -> full=1, count=8, write_address=0. 9th wr -> fifo_we=0, overflow=1. Then 8 reads -> empty=1, read_address=0, wrap bits both 1.
- Simultaneous at full (RETRANSMIT=0): rd=wr=1 -> both strobes 1, count stays 8. Same at empty -> fifo_we=1, fifo_rd=0, count becomes 1, underflow=1.
- Almost flags: writes 1..6 -> almost_empty drops when count=2; almost_full rises when count=6.
- Retransmit (RETRANSMIT=1): write 5, mark, read 3 -> count=2. rewind -> count=5, read_address=0. rd+rewind same cycle -> fifo_rd=0. With mark held at 0, after 3 more writes full=1 although count=8 only after rewind.
- Flush: with overflow=1 and count=4, pulse flush with wr=1 -> next cycle count=0, overflow=0, write_address=0.
